// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for a 16-entry register file.
// Each register keeps a small saturating count of in-flight writes; ID sources are checked against it.
module reg_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                issue_en,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic                retire_en,
  input  logic [ADDR_W-1:0]   retire_dest,
  input  logic [ADDR_W-1:0]   src1,
  input  logic [ADDR_W-1:0]   src2,
  input  logic                is_src1_valid,
  input  logic                two_src,
  output logic                hazard_detected,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                overflow_err,
  output logic                underflow_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                issue_accept;
  logic [NUM_REGS-1:0] ovf_hit;
  logic [NUM_REGS-1:0] unf_hit;
  logic                overflow_err_d, overflow_err_q;
  logic                underflow_err_d, underflow_err_q;

  // Hazard uses registered counts only; a retire this cycle does not release the stall yet.
  assign hazard_detected = (is_src1_valid && busy_vec[src1]) ||
                           (two_src && busy_vec[src2]);

  // A stalled ID re-presents its instruction, so an issue during a hazard is dropped.
  assign issue_accept = issue_en && !hazard_detected;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam logic [ADDR_W-1:0] IDX = ADDR_W'(gi);

    logic             inc;
    logic             dec;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    assign inc = issue_accept && (issue_dest == IDX);
    assign dec = retire_en && (retire_dest == IDX);

    // Simultaneous issue and retire to the same register cancel out.
    always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
        cnt_d = '0;
      end else if (inc && !dec && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (dec && !inc && (cnt_q != '0)) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    assign ovf_hit[gi]  = !flush && inc && !dec && (cnt_q == CNT_MAX);
    assign unf_hit[gi]  = !flush && dec && !inc && (cnt_q == '0);
    assign busy_vec[gi] = |cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  always_comb begin
    overflow_err_d  = overflow_err_q | (|ovf_hit);
    underflow_err_d = underflow_err_q | (|unf_hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_err_q  <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      overflow_err_q  <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign overflow_err  = overflow_err_q;
  assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: expected states are queued when stimulus is applied
// and popped against the DUT outputs once the relevant cycle has been reached.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic        retire_en;
  logic [3:0]  retire_dest;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        is_src1_valid;
  logic        two_src;
  logic        hazard_detected;
  logic [15:0] busy_vec;
  logic        overflow_err;
  logic        underflow_err;

  typedef struct {
    string       tag;
    logic        haz;
    logic [15:0] busy;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  reg_scoreboard #(.NUM_REGS(16), .ADDR_W(4), .CNT_W(2)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .issue_en        (issue_en),
    .issue_dest      (issue_dest),
    .retire_en       (retire_en),
    .retire_dest     (retire_dest),
    .src1            (src1),
    .src2            (src2),
    .is_src1_valid   (is_src1_valid),
    .two_src         (two_src),
    .hazard_detected (hazard_detected),
    .busy_vec        (busy_vec),
    .overflow_err    (overflow_err),
    .underflow_err   (underflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    flush = 0; issue_en = 0; issue_dest = 0; retire_en = 0; retire_dest = 0;
    src1 = 0; src2 = 0; is_src1_valid = 0; two_src = 0;
  endtask

  // Advance one rising edge and return at the following falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_state(input string tag, input logic haz, input logic [15:0] busy,
                              input logic ovf, input logic unf);
    exp_t e;
    e.tag = tag; e.haz = haz; e.busy = busy; e.ovf = ovf; e.unf = unf;
    exp_q.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty: observed no queued expectation, expected one");
      return;
    end
    e = exp_q.pop_front();
    compared++;
    assert (hazard_detected === e.haz) else begin
      mismatched++;
      $error("FAIL %s.hazard: observed %b expected %b", e.tag, hazard_detected, e.haz);
    end
    compared++;
    assert (busy_vec === e.busy) else begin
      mismatched++;
      $error("FAIL %s.busy_vec: observed %h expected %h", e.tag, busy_vec, e.busy);
    end
    compared++;
    assert (overflow_err === e.ovf) else begin
      mismatched++;
      $error("FAIL %s.overflow_err: observed %b expected %b", e.tag, overflow_err, e.ovf);
    end
    compared++;
    assert (underflow_err === e.unf) else begin
      mismatched++;
      $error("FAIL %s.underflow_err: observed %b expected %b", e.tag, underflow_err, e.unf);
    end
    $display("check %-16s haz=%b busy=%h ovf=%b unf=%b", e.tag, hazard_detected, busy_vec,
             overflow_err, underflow_err);
  endtask

  initial begin
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    expect_state("in_reset", 0, 16'h0000, 0, 0);
    check();
    rst_n = 1;

    // Reset state seen from a valid source lookup
    src1 = 3; is_src1_valid = 1;
    expect_state("post_reset", 0, 16'h0000, 0, 0);
    check();

    // Issue to R5 while reading R5: the issuer never sees its own write
    src1 = 5; issue_en = 1; issue_dest = 5;
    expect_state("self_no_haz", 0, 16'h0000, 0, 0);
    check();
    cyc();
    idle();
    src2 = 5; two_src = 1;
    expect_state("r5_pending", 1, 16'h0020, 0, 0);
    check();
    retire_en = 1; retire_dest = 5;
    expect_state("r5_retire_cyc", 1, 16'h0020, 0, 0);
    check();
    cyc();
    retire_en = 0;
    expect_state("r5_cleared", 0, 16'h0000, 0, 0);
    check();
    idle();

    // Same-cycle issue and retire on R7 with one in flight
    issue_en = 1; issue_dest = 7;
    cyc();
    expect_state("r7_one", 0, 16'h0080, 0, 0);
    check();
    retire_en = 1; retire_dest = 7;
    cyc();
    issue_en = 0;
    expect_state("r7_net_same", 0, 16'h0080, 0, 0);
    check();
    cyc();
    retire_en = 0;
    expect_state("r7_drained", 0, 16'h0000, 0, 0);
    check();

    // Issue R4 while retiring R9
    issue_en = 1; issue_dest = 9;
    cyc();
    expect_state("r9_one", 0, 16'h0200, 0, 0);
    check();
    issue_dest = 4; retire_en = 1; retire_dest = 9;
    cyc();
    issue_en = 0; retire_dest = 4;
    expect_state("r4_set_r9_clr", 0, 16'h0010, 0, 0);
    check();
    cyc();
    retire_en = 0;
    expect_state("r4_drained", 0, 16'h0000, 0, 0);
    check();

    // Saturate R2, then overflow
    issue_en = 1; issue_dest = 2;
    repeat (3) cyc();
    expect_state("r2_three", 0, 16'h0004, 0, 0);
    check();
    cyc();
    issue_en = 0;
    expect_state("r2_overflow", 0, 16'h0004, 1, 0);
    check();

    // Drain R2: held at 3, so exactly three retires empty it
    retire_en = 1; retire_dest = 2;
    repeat (2) cyc();
    expect_state("r2_one_left", 0, 16'h0004, 1, 0);
    check();
    cyc();
    expect_state("r2_empty", 0, 16'h0000, 1, 0);
    check();
    cyc();
    retire_en = 0;
    expect_state("r2_underflow", 0, 16'h0000, 1, 1);
    check();

    // Issue under hazard is dropped
    issue_en = 1; issue_dest = 6;
    cyc();
    issue_dest = 1; src1 = 6; is_src1_valid = 1;
    expect_state("stall_on_r6", 1, 16'h0040, 1, 1);
    check();
    cyc();
    issue_en = 0; is_src1_valid = 0;
    expect_state("r1_ignored", 0, 16'h0040, 1, 1);
    check();

    // Flush beats a concurrent issue and keeps the sticky errors
    flush = 1; issue_en = 1; issue_dest = 8;
    cyc();
    idle();
    expect_state("after_flush", 0, 16'h0000, 1, 1);
    check();

    // Load R4..R7 then drop reset between edges
    issue_en = 1;
    for (int r = 4; r < 8; r++) begin
      issue_dest = 4'(r);
      cyc();
    end
    idle();
    src1 = 5; is_src1_valid = 1;
    expect_state("busy_f0", 1, 16'h00F0, 1, 1);
    check();
    @(posedge clk);
    #2;
    rst_n = 0;
    expect_state("async_reset", 0, 16'h0000, 0, 0);
    check();
    @(negedge clk);
    rst_n = 1;
    idle();

    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_leftover: observed %0d queued, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
